// File: rtl/timer_counter_pkg.sv
// ---------------------------------------------------------------------------
// timer_counter_pkg
// Shared definitions for the timer_counter block:
//   - FSM state encoding
//   - register byte offsets and the word indices decoded from Addr[3:2]
//   - CTRL bit positions and Mode values
//   - merge_bytes(): byte-lane write merge helper
// ---------------------------------------------------------------------------
package timer_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   // Byte offsets inside the 16-byte register window
   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_PRESET = 4'h4;
   localparam logic [3:0] OFF_COUNT  = 4'h8;

   // Word indices as seen on Addr[3:2]
   localparam logic [1:0] IDX_CTRL   = OFF_CTRL[3:2];
   localparam logic [1:0] IDX_PRESET = OFF_PRESET[3:2];
   localparam logic [1:0] IDX_COUNT  = OFF_COUNT[3:2];

   // CTRL bit positions
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;

   // Mode values; 2 and 3 are treated as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_AUTO    = 2'd1;

   // Replace only the byte lanes whose enable bit is set
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
// Memory-mapped down-counter with interrupt. Only Addr[3:2] is decoded, so
// the block can sit at any 16-byte aligned base behind the system bridge
// (e.g. two instances at 0x7F00 and 0x7F10).
//
// Registers (Addr[3:2]):
//   0 CTRL   : bit0 En, bits[2:1] Mode (1 = auto-reload, else one-shot),
//              bit3 IM (IRQ mask); other bits read 0
//   1 PRESET : 32-bit read/write reload value
//   2 COUNT  : 32-bit read-only current count
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   Addr   : word address [31:2]
//   WE     : write strobe (already qualified by the bridge)
//   byteen : byte-lane write enables (only when TC_BYTEEN_EN is defined)
//   Din    : write data
//   Dout   : combinational read data
//   IRQ    : interrupt request = irq_flag & CTRL.IM
//
// Configuration macro: TC_BYTEEN_EN adds the byteen port; otherwise every
// write is full-word.
// ---------------------------------------------------------------------------
module timer_counter
   import timer_counter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
`ifdef TC_BYTEEN_EN
   input  logic [3:0]  byteen,
`endif
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   state_t      state;
   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;

   logic [3:0]  lanes;
   logic [31:0] ctrl_word;
   logic [31:0] ctrl_new;
   logic [31:0] preset_new;
   logic        ctrl_wr;
   logic        preset_wr;
   logic        unused_addr_bits;

`ifdef TC_BYTEEN_EN
   assign lanes = byteen;
`else
   assign lanes = 4'hF;
`endif

   // Upper address bits are decoded by the bridge, not here
   assign unused_addr_bits = ^Addr[31:4];

   assign ctrl_word  = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
   assign ctrl_new   = merge_bytes(ctrl_word, Din, lanes);
   assign preset_new = merge_bytes(preset, Din, lanes);

   // A write with no lanes enabled is a no-op, including its irq_flag clear
   assign ctrl_wr   = WE && (Addr[3:2] == IDX_CTRL)   && (lanes != 4'h0);
   assign preset_wr = WE && (Addr[3:2] == IDX_PRESET) && (lanes != 4'h0);

   assign IRQ = irq_flag & ctrl_im;

   // Read mux: reflects register contents, no side effects
   always_comb begin
      Dout = 32'd0;
      case (Addr[3:2])
         IDX_CTRL:   Dout = ctrl_word;
         IDX_PRESET: Dout = preset;
         IDX_COUNT:  Dout = count;
         default:    Dout = 32'd0;
      endcase
   end

   // Register file and counting FSM; CPU CTRL write is applied last so it
   // overrides the FSM's En clear and irq_flag update in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         ctrl_en   <= 1'b0;
         ctrl_mode <= MODE_ONESHOT;
         ctrl_im   <= 1'b0;
         preset    <= 32'd0;
         count     <= 32'd0;
         irq_flag  <= 1'b0;
      end else begin
         if (preset_wr) begin
            preset <= preset_new;
         end

         case (state)
            ST_IDLE: begin
               if (ctrl_en) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!ctrl_en) begin
                  state <= ST_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  // 0 and 1 both terminate on this edge
                  count    <= 32'd0;
                  irq_flag <= 1'b1;
                  state    <= ST_INT;
               end
            end
            ST_INT: begin
               if (ctrl_mode == MODE_AUTO) begin
                  irq_flag <= 1'b0;   // one-cycle pulse, En kept for reload
               end else begin
                  ctrl_en <= 1'b0;    // one-shot: flag held until CTRL write
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (ctrl_wr) begin
            ctrl_en   <= ctrl_new[CTRL_EN_BIT];
            ctrl_mode <= ctrl_new[CTRL_MODE_MSB:CTRL_MODE_LSB];
            ctrl_im   <= ctrl_new[CTRL_IM_BIT];
            irq_flag  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
// Self-checking bench for timer_counter: directed scenarios plus a random
// phase, all compared every cycle against a behavioural model of the
// register/timer rules. Define TC_BYTEEN_EN to exercise byte-lane writes.
// ---------------------------------------------------------------------------
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [31:2] Addr;
   logic        WE;
`ifdef TC_BYTEEN_EN
   logic [3:0]  byteen;
`endif
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int checks   = 0;
   int failures = 0;

   // Model of the visible architecture
   logic [31:0] m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   logic        m_irq_flag;
   string       m_phase;

   timer_counter dut (
      .clk    (clk),
      .reset  (reset),
      .Addr   (Addr),
      .WE     (WE),
`ifdef TC_BYTEEN_EN
      .byteen (byteen),
`endif
      .Din    (Din),
      .Dout   (Dout),
      .IRQ    (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   // One clock edge of the behavioural model, from pre-edge values
   task automatic model_edge(input bit rst, input bit we, input logic [1:0] a,
                             input logic [31:0] d, input logic [3:0] be);
      logic [31:0] n_ctrl, n_preset, n_count;
      logic        n_irq;
      string       n_phase;
      if (rst) begin
         m_ctrl = 32'd0; m_preset = 32'd0; m_count = 32'd0;
         m_irq_flag = 1'b0; m_phase = "IDLE";
         return;
      end
      n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
      n_irq = m_irq_flag; n_phase = m_phase;
      if (we && a == 2'd1 && be != 4'd0) n_preset = lane_merge(m_preset, d, be);
      if (m_phase == "IDLE") begin
         if (m_ctrl[0]) n_phase = "LOAD";
      end else if (m_phase == "LOAD") begin
         n_count = m_preset;
         n_phase = "CNT";
      end else if (m_phase == "CNT") begin
         if (!m_ctrl[0]) n_phase = "IDLE";
         else if (m_count >= 32'd2) n_count = m_count - 32'd1;
         else begin
            n_count = 32'd0; n_irq = 1'b1; n_phase = "INT";
         end
      end else begin
         if (m_ctrl[2:1] == 2'd1) n_irq = 1'b0;
         else n_ctrl[0] = 1'b0;
         n_phase = "IDLE";
      end
      if (we && a == 2'd0 && be != 4'd0) begin
         n_ctrl = lane_merge(m_ctrl, d, be) & 32'h0000_000F;
         n_irq  = 1'b0;
      end
      m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
      m_irq_flag = n_irq; m_phase = n_phase;
   endtask

   // Read every register through Dout and compare with the model
   task automatic compare_all(input string tag);
      Addr = 30'd0; #1; check({tag, ".ctrl"},   Dout, m_ctrl);
      Addr = 30'd1; #1; check({tag, ".preset"}, Dout, m_preset);
      Addr = 30'd2; #1; check({tag, ".count"},  Dout, m_count);
      Addr = 30'd3; #1; check({tag, ".rsvd"},   Dout, 32'd0);
      check({tag, ".irq"}, {31'd0, IRQ}, {31'd0, m_irq_flag & m_ctrl[3]});
   endtask

   // Apply one cycle of inputs, advance model and DUT, then compare
   task automatic step(input string tag, input bit rst_i, input bit we_i, input logic [1:0] a_i,
                       input logic [31:0] d_i, input logic [3:0] be_i);
      logic [3:0] eff_be;
`ifdef TC_BYTEEN_EN
      byteen = be_i;
      eff_be = be_i;
`else
      eff_be = be_i | 4'hF;   // no byte lanes: every write is full-word
`endif
      reset = rst_i; WE = we_i; Addr = {28'd0, a_i}; Din = d_i;
      @(posedge clk);
      model_edge(rst_i, we_i, a_i, d_i, eff_be);
      #1;
      reset = 1'b0; WE = 1'b0;
      compare_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 2'd0, 32'd0, 4'hF);
   endtask

   initial begin
      int hi_edges[$];
      bit seen;
      reset = 1'b1; WE = 1'b0; Addr = 30'd0; Din = 32'd0;
`ifdef TC_BYTEEN_EN
      byteen = 4'hF;
`endif
      m_ctrl = 32'd0; m_preset = 32'd0; m_count = 32'd0;
      m_irq_flag = 1'b0; m_phase = "IDLE";

      // Reset: every offset reads 0 and IRQ is low
      step("reset", 1'b1, 1'b0, 2'd0, 32'd0, 4'hF);
      Addr = 30'd0; #1; check("rst_ctrl", Dout, 32'd0);
      Addr = 30'd1; #1; check("rst_preset", Dout, 32'd0);
      Addr = 30'd2; #1; check("rst_count", Dout, 32'd0);
      check("rst_irq", {31'd0, IRQ}, 32'd0);

      // One-shot, PRESET=5, CTRL=En|IM
      step("os_pre", 1'b0, 1'b1, 2'd1, 32'd5, 4'hF);
      step("os_ctl", 1'b0, 1'b1, 2'd0, 32'h9, 4'hF);
      begin
         logic [31:0] exp_seq [7];
         exp_seq = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
         for (int i = 0; i < 7; i++) begin
            idle("os_run");
            Addr = 30'd2; #1; check("os_seq", Dout, exp_seq[i]);
         end
      end
      check("os_irq_at_zero", {31'd0, IRQ}, 32'd1);
      idle("os_int");
      Addr = 30'd0; #1; check("os_en_cleared", Dout, 32'h8);
      for (int i = 0; i < 4; i++) idle("os_hold");
      check("os_irq_held", {31'd0, IRQ}, 32'd1);
      step("os_clr", 1'b0, 1'b1, 2'd0, 32'h8, 4'hF);
      check("os_irq_cleared", {31'd0, IRQ}, 32'd0);

      // Auto-reload, PRESET=3: 1-cycle pulse every 6 cycles
      step("ar_rst", 1'b1, 1'b0, 2'd0, 32'd0, 4'hF);
      step("ar_pre", 1'b0, 1'b1, 2'd1, 32'd3, 4'hF);
      step("ar_ctl", 1'b0, 1'b1, 2'd0, 32'hB, 4'hF);
      for (int i = 1; i <= 24; i++) begin
         idle("ar_run");
         if (IRQ === 1'b1) hi_edges.push_back(i);
      end
      check("ar_pulses", hi_edges.size(), 32'd4);
      if (hi_edges.size() > 0) check("ar_first", hi_edges[0], 32'd5);
      for (int i = 1; i < hi_edges.size(); i++)
         check("ar_period", hi_edges[i] - hi_edges[i-1], 32'd6);

      // Stop mid-count: COUNT holds, COUNT write ignored
      step("st_rst", 1'b1, 1'b0, 2'd0, 32'd0, 4'hF);
      step("st_pre", 1'b0, 1'b1, 2'd1, 32'd10, 4'hF);
      step("st_ctl", 1'b0, 1'b1, 2'd0, 32'h1, 4'hF);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         idle("st_run");
         Addr = 30'd2; #1;
         if (Dout == 32'd7) seen = 1'b1;
      end
      check("st_reached7", {31'd0, seen}, 32'd1);
      step("st_stop", 1'b0, 1'b1, 2'd0, 32'h0, 4'hF);
      for (int i = 0; i < 3; i++) idle("st_idle");
      Addr = 30'd2; #1; check("st_hold6", Dout, 32'd6);
      step("st_cntwr", 1'b0, 1'b1, 2'd2, 32'h55, 4'hF);
      Addr = 30'd2; #1; check("st_cnt_ro", Dout, 32'd6);
      check("st_irq", {31'd0, IRQ}, 32'd0);

      // IM=0: flag set internally but IRQ low; CTRL write clears the flag
      step("im_pre", 1'b0, 1'b1, 2'd1, 32'd2, 4'hF);
      step("im_ctl", 1'b0, 1'b1, 2'd0, 32'h1, 4'hF);
      for (int i = 0; i < 6; i++) idle("im_run");
      check("im_masked", {31'd0, IRQ}, 32'd0);
      step("im_unmask", 1'b0, 1'b1, 2'd0, 32'h8, 4'hF);
      check("im_irq_after", {31'd0, IRQ}, 32'd0);

      // PRESET 0 and 1 terminate on the first counting edge
      for (int p = 0; p < 2; p++) begin
         step("pz_rst", 1'b1, 1'b0, 2'd0, 32'd0, 4'hF);
         step("pz_pre", 1'b0, 1'b1, 2'd1, p, 4'hF);
         step("pz_ctl", 1'b0, 1'b1, 2'd0, 32'h9, 4'hF);
         for (int i = 0; i < 3; i++) idle("pz_run");
         check("pz_irq", {31'd0, IRQ}, 32'd1);
      end

`ifdef TC_BYTEEN_EN
      step("be_rst", 1'b1, 1'b0, 2'd0, 32'd0, 4'hF);
      step("be_pre", 1'b0, 1'b1, 2'd1, 32'h1122_3344, 4'hF);
      step("be_lane", 1'b0, 1'b1, 2'd1, 32'hAABB_CCDD, 4'b0100);
      Addr = 30'd1; #1; check("be_merge", Dout, 32'h11BB_3344);
      step("be_none", 1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 4'b0000);
      Addr = 30'd1; #1; check("be_nowrite", Dout, 32'h11BB_3344);
      step("be_ctl", 1'b0, 1'b1, 2'd0, 32'h9, 4'hF);
      for (int i = 0; i < 4; i++) idle("be_run");
      step("be_midrst", 1'b1, 1'b1, 2'd1, 32'h1234_5678, 4'hF);
      Addr = 30'd2; #1; check("be_rst_count", Dout, 32'd0);
`endif

      // Random phase against the model
      for (int i = 0; i < 600; i++) begin
         bit          r_rst, r_we;
         logic [1:0]  r_a;
         logic [31:0] r_d;
         logic [3:0]  r_be;
         r_rst = ($urandom_range(0, 49) == 0);
         r_we  = ($urandom_range(0, 3) == 0);
         r_a   = 2'($urandom_range(0, 3));
         r_be  = 4'($urandom_range(0, 15));
         if (r_a == 2'd1 && $urandom_range(0, 7) != 0) r_d = 32'($urandom_range(0, 8));
         else if (r_a == 2'd0) r_d = {$urandom} & 32'hFFFF_FFF1 | ({$urandom} & 32'h0000_000E);
         else r_d = $urandom;
         step("rand", r_rst, r_we, r_a, r_d, r_be);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
